game_controller: RTL and testbench

- Central sequencer for the shooter game.
- Owns the game state machine (idle, playing, paused, respawn, game over) and derives one update strobe per frame-divider period from VGA vertical sync.
- Keeps score (4-digit BCD, feeds HEX0..HEX3) and lives; drives `perdeu` into tela and the update/restart strobes into entities.
- Sits in projeto between keys/vga/entities and tela.

---
 rtl/game_pkg.sv | 36 +++
 rtl/bcd_counter4.sv | 44 ++++
 rtl/game_controller.sv | 191 +++++++++++++++++++
 tb/tb_game_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the shooter game sequencer:
// state encodings, BCD score geometry and a BCD magnitude compare.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam int          BCD_DIGITS  = 4;
    localparam logic [15:0] SCORE_MAX   = 16'h9999;

    // Most significant digit decides first; equal digits fall through.
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (!decided) begin
                if (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > b[i*BCD_DIGIT_W +: BCD_DIGIT_W]) begin
                    gt      = 1'b1;
                    decided = 1'b1;
                end else if (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] < b[i*BCD_DIGIT_W +: BCD_DIGIT_W]) begin
                    decided = 1'b1;
                end
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear/enable, saturating at 9999.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [15:0] o_value
);

    logic [15:0] r_value;
    logic [15:0] w_next;
    logic        w_carry;

    // Ripple the +1 upward; a digit at 9 wraps to 0 and passes the carry on.
    always_comb begin
        w_next  = r_value;
        w_carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (w_carry) begin
                if (r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                    w_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    w_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] = r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= 16'h0000;
        end else if (i_clr) begin
            r_value <= 16'h0000;
        end else if (i_en && (r_value != SCORE_MAX)) begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: state machine, vsync-derived frame/tick strobes, BCD score and lives.
// Optional high-score register enabled by defining GAME_CONTROLLER_HISCORE_EN.
module game_controller
    import game_pkg::*;
#(
    parameter int FRAME_DIV      = 2,
    parameter int VIDAS_INICIAIS = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        pausa,
    input  logic        vga_vs,
    input  logic        hit_inimigo,
    input  logic        hit_nave,
    output logic [2:0]  estado,
    output logic        tick_entidades,
    output logic        reinicia_entidades,
    output logic        perdeu,
    output logic [15:0] pontos,
`ifdef GAME_CONTROLLER_HISCORE_EN
    output logic [1:0]  vidas,
    output logic [15:0] recorde
`else
    output logic [1:0]  vidas
`endif
);

    localparam logic [3:0] DIV_LAST  = 4'(FRAME_DIV - 1);
    localparam logic [7:0] RESP_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [1:0] VIDAS_INI = 2'(VIDAS_INICIAIS);

    logic        r_rst_s1;
    logic        r_rst_s2;
    logic        w_rst_n;
    logic        r_vs_s1;
    logic        r_vs_s2;
    logic        r_vs_d;
    logic        r_frame_pulse;
    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_frame_cnt;
    logic [7:0]  r_resp_cnt;
    logic [1:0]  r_vidas;
    logic        r_tick;
    logic        r_reinicia;
    logic        r_perdeu;
    logic        w_new_game;
    logic        w_resp_done;
    logic        w_tick_now;
    logic        w_score_en;
    logic        w_playing;
    logic [15:0] w_pontos;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_rst_s1 <= 1'b0;
            r_rst_s2 <= 1'b0;
        end else begin
            r_rst_s1 <= 1'b1;
            r_rst_s2 <= r_rst_s1;
        end
    end

    assign w_rst_n = r_rst_s2;

    // Two-flop vsync synchronizer plus registered falling-edge detect.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vs_s1       <= 1'b1;
            r_vs_s2       <= 1'b1;
            r_vs_d        <= 1'b1;
            r_frame_pulse <= 1'b0;
        end else begin
            r_vs_s1       <= vga_vs;
            r_vs_s2       <= r_vs_s1;
            r_vs_d        <= r_vs_s2;
            r_frame_pulse <= r_vs_d & ~r_vs_s2;
        end
    end

    assign w_playing   = (r_state == ST_PLAYING);
    assign w_new_game  = start && ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));
    assign w_resp_done = (r_state == ST_RESPAWN) && r_frame_pulse && (r_resp_cnt == RESP_LAST);
    assign w_tick_now  = w_playing && r_frame_pulse && (r_frame_cnt == DIV_LAST);
    assign w_score_en  = w_playing && hit_inimigo;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A lost life outranks a pause request in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) w_next_state = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (hit_nave) begin
                    w_next_state = (r_vidas > 2'd1) ? ST_RESPAWN : ST_GAME_OVER;
                end else if (pausa) begin
                    w_next_state = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!pausa) w_next_state = ST_PLAYING;
            end
            ST_RESPAWN: begin
                if (w_resp_done) w_next_state = ST_PLAYING;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tick      <= 1'b0;
            r_reinicia  <= 1'b0;
            r_perdeu    <= 1'b0;
            r_frame_cnt <= 4'd0;
            r_resp_cnt  <= 8'd0;
            r_vidas     <= 2'd0;
        end else begin
            r_tick     <= w_tick_now;
            r_reinicia <= w_new_game || w_resp_done;
            r_perdeu   <= (w_next_state == ST_GAME_OVER);

            // Divider holds its count through PAUSED; only fresh entries clear it.
            if (w_new_game || w_resp_done) begin
                r_frame_cnt <= 4'd0;
            end else if (w_playing && r_frame_pulse) begin
                r_frame_cnt <= w_tick_now ? 4'd0 : r_frame_cnt + 4'd1;
            end

            if (w_playing && hit_nave) begin
                r_resp_cnt <= 8'd0;
            end else if ((r_state == ST_RESPAWN) && r_frame_pulse) begin
                r_resp_cnt <= r_resp_cnt + 8'd1;
            end

            if (w_new_game) begin
                r_vidas <= VIDAS_INI;
            end else if (w_playing && hit_nave) begin
                r_vidas <= (r_vidas > 2'd1) ? r_vidas - 2'd1 : 2'd0;
            end
        end
    end

    bcd_counter4 u_score (
        .i_clk   (CLOCK_50),
        .i_rst_n (w_rst_n),
        .i_clr   (w_new_game),
        .i_en    (w_score_en),
        .o_value (w_pontos)
    );

`ifdef GAME_CONTROLLER_HISCORE_EN
    logic [15:0] r_recorde;
    logic        r_go_entry;

    // Compare one cycle after entering GAME_OVER so the final hit is already counted.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_recorde  <= 16'h0000;
            r_go_entry <= 1'b0;
        end else begin
            r_go_entry <= (r_state != ST_GAME_OVER) && (w_next_state == ST_GAME_OVER);
            if (r_go_entry && bcd_gt(w_pontos, r_recorde)) begin
                r_recorde <= w_pontos;
            end
        end
    end

    assign recorde = r_recorde;
`endif

    assign estado             = r_state;
    assign tick_entidades     = r_tick;
    assign reinicia_entidades = r_reinicia;
    assign perdeu             = r_perdeu;
    assign pontos             = w_pontos;
    assign vidas              = r_vidas;

endmodule

// File: tb/tb_game_controller.sv
// Randomized bench for game_controller against a behavioural game model
// (integer score, integer lives, frame events from the vsync history).
`timescale 1ns/1ps
module tb_game_controller;

    localparam int FD = 2;
    localparam int VI = 3;
    localparam int RF = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pausa = 1'b0;
    logic        vga_vs = 1'b1;
    logic        hit_inimigo = 1'b0;
    logic        hit_nave = 1'b0;
    logic [2:0]  estado;
    logic        tick_entidades;
    logic        reinicia_entidades;
    logic        perdeu;
    logic [15:0] pontos;
    logic [1:0]  vidas;
`ifdef GAME_CONTROLLER_HISCORE_EN
    logic [15:0] recorde;
`endif

    game_controller #(.FRAME_DIV(FD), .VIDAS_INICIAIS(VI), .RESPAWN_FRAMES(RF)) dut (
        .CLOCK_50           (clk),
        .reset              (reset),
        .start              (start),
        .pausa              (pausa),
        .vga_vs             (vga_vs),
        .hit_inimigo        (hit_inimigo),
        .hit_nave           (hit_nave),
        .estado             (estado),
        .tick_entidades     (tick_entidades),
        .reinicia_entidades (reinicia_entidades),
        .perdeu             (perdeu),
        .pontos             (pontos),
`ifdef GAME_CONTROLLER_HISCORE_EN
        .vidas              (vidas),
        .recorde            (recorde)
`else
        .vidas              (vidas)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: 0 idle, 1 playing, 2 paused, 3 respawn, 4 game over.
    int m_state, m_score, m_vidas, m_fcnt, m_rcnt, m_rec;
    bit m_tick, m_rein, m_perdeu, m_goent;
    bit vs_hist [1:4];
    int vs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_vidas = 0; m_fcnt = 0; m_rcnt = 0; m_rec = 0;
        m_tick = 0; m_rein = 0; m_perdeu = 0; m_goent = 0;
        for (int k = 1; k <= 4; k++) vs_hist[k] = 1'b1;
        vs_cnt = 8;
    endtask

    task automatic model_step(input bit st, input bit pz, input bit hi, input bit hn, input bit fp);
        int s0;
        s0 = m_state;
        if (m_goent && m_score > m_rec) m_rec = m_score;
        m_goent = 0;
        m_tick  = 0;
        m_rein  = 0;
        case (s0)
            0, 4: if (st) begin
                m_score = 0; m_vidas = VI; m_rein = 1; m_fcnt = 0; m_state = 1;
            end
            1: begin
                if (hi && m_score < 9999) m_score++;
                if (fp) begin
                    m_fcnt++;
                    if (m_fcnt == FD) begin m_tick = 1; m_fcnt = 0; end
                end
                if (hn) begin
                    if (m_vidas > 1) begin m_vidas--; m_state = 3; m_rcnt = 0; end
                    else begin m_vidas = 0; m_state = 4; m_goent = 1; end
                end else if (pz) begin
                    m_state = 2;
                end
            end
            2: if (!pz) m_state = 1;
            3: if (fp) begin
                m_rcnt++;
                if (m_rcnt == RF) begin m_rein = 1; m_fcnt = 0; m_state = 1; end
            end
            default: ;
        endcase
        m_perdeu = (m_state == 4);
    endtask

    // One clock: drive at negedge, advance the model, compare after posedge.
    task automatic cyc(input bit st, input bit pz, input bit hi, input bit hn);
        bit fp;
        @(negedge clk);
        start = st; pausa = pz; hit_inimigo = hi; hit_nave = hn;
        if (vs_cnt == 0) begin
            vga_vs = ~vga_vs;
            vs_cnt = $urandom_range(3, 6);
        end else begin
            vs_cnt--;
        end
        fp = vs_hist[4] & ~vs_hist[3];
        model_step(st, pz, hi, hn, fp);
        vs_hist[4] = vs_hist[3]; vs_hist[3] = vs_hist[2]; vs_hist[2] = vs_hist[1]; vs_hist[1] = vga_vs;
        @(posedge clk);
        #1;
        chk("estado", 32'(estado), 32'(m_state));
        chk("tick", 32'(tick_entidades), 32'(m_tick));
        chk("reinicia", 32'(reinicia_entidades), 32'(m_rein));
        chk("perdeu", 32'(perdeu), 32'(m_perdeu));
        chk("pontos", 32'(pontos), 32'(to_bcd(m_score)));
        chk("vidas", 32'(vidas), 32'(m_vidas));
`ifdef GAME_CONTROLLER_HISCORE_EN
        chk("recorde", 32'(recorde), 32'(to_bcd(m_rec)));
`endif
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_estado"}, 32'(estado), 32'd0);
        chk({tag, "_tick"}, 32'(tick_entidades), 32'd0);
        chk({tag, "_reinicia"}, 32'(reinicia_entidades), 32'd0);
        chk({tag, "_perdeu"}, 32'(perdeu), 32'd0);
        chk({tag, "_pontos"}, 32'(pontos), 32'd0);
        chk({tag, "_vidas"}, 32'(vidas), 32'd0);
`ifdef GAME_CONTROLLER_HISCORE_EN
        chk({tag, "_recorde"}, 32'(recorde), 32'd0);
`endif
    endtask

    // Assert reset away from the clock edge, verify, then release and settle.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        start = 0; pausa = 0; hit_inimigo = 0; hit_nave = 0; vga_vs = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) cyc(0, 0, 0, 0);
    endtask

    initial begin
        bit pz;
        int guard;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // New game from idle.
        cyc(1, 0, 0, 0);
        chk("start_estado", 32'(estado), 32'd1);
        chk("start_vidas", 32'(vidas), 32'(VI));
        chk("start_reinicia", 32'(reinicia_entidades), 32'd1);
        cyc(0, 0, 0, 0);
        chk("start_reinicia_once", 32'(reinicia_entidades), 32'd0);

        // Random play.
        pz = 0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 59) == 0) pz = ~pz;
            cyc($urandom_range(0, 29) == 0, pz, $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
        end

        // Score carry and saturation.
        do_reset("rst1");
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 10005; i++) begin
            cyc(0, 0, 1, 0);
            if (i == 99)  chk("bcd_0099", 32'(pontos), 32'h0099);
            if (i == 100) chk("bcd_0100", 32'(pontos), 32'h0100);
        end
        chk("bcd_sat", 32'(pontos), 32'h9999);
        cyc(0, 0, 0, 0);

        // Pause mid frame-count, resume, pause again, then reset while paused.
        for (int i = 0; i < 13; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
        chk("paused", 32'(estado), 32'd2);
        for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
        chk("paused2", 32'(estado), 32'd2);
        do_reset("rst_pause");

        // Game 1: small score, lose all lives.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        guard = 0;
        while (m_state != 4 && guard < 5000) begin
            cyc(0, 0, 0, m_state == 1);
            guard++;
        end
        chk("go1_estado", 32'(estado), 32'd4);
        cyc(0, 0, 1, 1);
        chk("go1_frozen_pontos", 32'(pontos), 32'h0005);
`ifdef GAME_CONTROLLER_HISCORE_EN
        chk("go1_recorde", 32'(recorde), 32'h0005);
`endif

        // Game 2: simultaneous hits on the last life.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0);
        guard = 0;
        while (m_state != 4 && guard < 5000) begin
            cyc(0, 0, (m_state == 1) && (m_vidas == 1), m_state == 1);
            guard++;
        end
        chk("go2_estado", 32'(estado), 32'd4);
        chk("go2_perdeu", 32'(perdeu), 32'd1);
        chk("go2_vidas", 32'(vidas), 32'd0);
        chk("go2_pontos", 32'(pontos), 32'h0012);
        cyc(0, 0, 0, 0);
`ifdef GAME_CONTROLLER_HISCORE_EN
        chk("go2_recorde", 32'(recorde), 32'h0012);
`endif
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
